pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 32: width of the datapath payload (ALU result, load data, etc. concatenated by the instantiating stage).
REQ-002 Parameter CTRL_W, default 8: width of the control payload (wb_en, wb_sel, ecall, func3, rd index, ...).
REQ-003 Parameter SKID, default 1: 1 = two-entry skid buffer (full throughput); 0 = single entry (bubble after each backpressure release).
REQ-004 Parameter CTRL_GATE, default 1: 1 = out_ctrl forced to zero while out_valid=0.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 in_valid  in  1  upstream stage holds a valid instruction.
REQ-008 in_ready  out  1  this stage accepts in_data/in_ctrl this cycle.
REQ-009 in_data  in  DATA_W  upstream datapath payload.
REQ-010 in_ctrl  in  CTRL_W  upstream control payload.
REQ-011 flush  in  1  synchronous kill of all held entries (branch/trap redirect).
REQ-012 out_valid  out  1  head entry valid.
REQ-013 out_ready  in  1  downstream consumes the head entry this cycle.
REQ-014 out_data  out  DATA_W  head datapath payload.
REQ-015 out_ctrl  out  CTRL_W  head control payload.
REQ-016 occupancy  out  2  number of held entries (0..2).

Function
REQ-017 Transfer in = in_valid & in_ready; transfer out = out_valid & out_ready.
REQ-018 States EMPTY, ONE, TWO (TWO only if SKID=1); occupancy = 0/1/2 accordingly.
REQ-019 EMPTY: in-transfer -> ONE, head loaded with input.
REQ-020 ONE: in-transfer and out-transfer -> ONE, head replaced by input (zero-bubble pass-through).
REQ-021 ONE: in-transfer only -> TWO, input stored in skid slot (SKID=1).
REQ-022 ONE: out-transfer only -> EMPTY.
REQ-023 TWO: out-transfer -> ONE, skid slot moves to head; no in-transfer possible.
REQ-024 in_ready is registered-state only: 1 in EMPTY/ONE (SKID=1), 0 in TWO; with SKID=0, in_ready = (EMPTY) | out_ready.
REQ-025 in_ready never depends combinationally on out_ready when SKID=1.
REQ-026 Latency: accepted entry appears on out_* the cycle after acceptance; ordering strictly FIFO.
REQ-027 Held payloads stable while out_valid=1 and out_ready=0.
REQ-028 flush=1: next state EMPTY, both valid bits cleared; an in_valid in the same cycle is dropped; in_ready still reflects pre-flush state.
REQ-029 CTRL_GATE=1: out_ctrl = 0 when out_valid=0, so a bubble never asserts write-back or ecall.
REQ-030 out_data holds last value when out_valid=0 (no gating; saves muxes).

Reset
REQ-031 rst=0 asynchronously forces EMPTY; out_valid=0, occupancy=0, in_ready=1 (SKID=1) or 1 (SKID=0).
REQ-032 All payload registers reset to 0; out_data=0, out_ctrl=0.
REQ-033 Reset release mid-operation: first in-transfer occurs no earlier than the first rising edge with rst=1.

Structure
REQ-034 Shared package pipe_pkg holds the state enumeration (EMPTY, ONE, TWO) and default width constants.
REQ-035 One sub-module pipe_slot: a DATA_W+CTRL_W register with load enable and async active-low reset, instantiated as head and skid slot.

Verification
REQ-036 Stream 8 entries (data 0x100..0x107) with out_ready=1 -> outputs 0x100..0x107 on consecutive cycles, occupancy never 2.
REQ-037 Two in-transfers (0xA, 0xB) with out_ready=0 -> occupancy 2, in_ready=0, out_data=0xA held; raise out_ready -> 0xA then 0xB, in_ready=1 after first pop.
REQ-038 Occupancy 2, flush=1 with in_valid=1 data 0xC -> next cycle out_valid=0, occupancy 0, 0xC never appears on output.
REQ-039 in_ctrl=0xFF, then idle -> out_ctrl=0xFF for one cycle, then 0x00 while out_valid=0 (CTRL_GATE=1).
REQ-040 Assert rst=0 between clock edges while occupancy=2 -> out_valid, occupancy, out_data, out_ctrl go to 0 immediately.
REQ-041 SKID=0, out_ready toggled 1,0,1 under continuous in_valid -> no loss or duplication, in_ready = out_ready while ONE.

Source files
------------

// File: rtl/pipe_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : pipe_pkg                                             |
// | Description : Shared definitions for the pipeline stage register:  |
// |               occupancy state enumeration, default payload widths, |
// |               and a state-to-occupancy helper.                     |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
package pipe_pkg;

   localparam int C_DATA_W = 32;
   localparam int C_CTRL_W = 8;

   // Encoding equals the number of held entries, so occupancy is the state itself.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } pipe_state_t;

   function automatic logic [1:0] occ_of(input pipe_state_t s);
      return s;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_stage_reg_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : pipe_stage_reg_if                                    |
// | Description : Handshake bundle of one pipeline stage register.     |
// |               Upstream side : in_valid, in_ready, in_data, in_ctrl |
// |               Downstream    : out_valid, out_ready, out_data,      |
// |                               out_ctrl                             |
// |               Side-band     : flush (kill), occupancy (0..2)       |
// |               slave  = the stage register's view                   |
// |               master = the surrounding pipeline's view             |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
interface pipe_stage_reg_if
   import pipe_pkg::*;
#(
   parameter int DATA_W = C_DATA_W,
   parameter int CTRL_W = C_CTRL_W
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [CTRL_W-1:0] in_ctrl;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [CTRL_W-1:0] out_ctrl;
   logic [1:0]        occupancy;

   modport master (
      output in_valid, in_data, in_ctrl, flush, out_ready,
      input  in_ready, out_valid, out_data, out_ctrl, occupancy
   );

   modport slave (
      input  in_valid, in_data, in_ctrl, flush, out_ready,
      output in_ready, out_valid, out_data, out_ctrl, occupancy
   );

endinterface
`default_nettype wire

// File: rtl/pipe_slot.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : pipe_slot                                            |
// | Description : One payload entry (data + control) with load enable. |
// |               clk - clock, rst - async active-low reset to zero,   |
// |               ld  - capture d on the rising edge, q - held value.  |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module pipe_slot #(
   parameter int W = 40
) (
   input  wire logic         clk,
   input  wire logic         rst,
   input  wire logic         ld,
   input  wire logic [W-1:0] d,
   output logic      [W-1:0] q
);

   logic [W-1:0] r_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_q <= '0;
      end else if (ld) begin
         r_q <= d;
      end
   end

   assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : pipe_stage_reg                                       |
// | Description : Valid/ready pipeline stage register with optional    |
// |               skid entry and control gating for bubbles.           |
// |               clk - clock, rst - async active-low reset            |
// |               bus - pipe_stage_reg_if.slave (in_*, out_*, flush,   |
// |                     occupancy)                                     |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W    = C_DATA_W,
   parameter int CTRL_W    = C_CTRL_W,
   parameter int SKID      = 1,
   parameter int CTRL_GATE = 1
) (
   input  wire logic       clk,
   input  wire logic       rst,
   pipe_stage_reg_if.slave bus
);

   localparam int c_slot_w = DATA_W + CTRL_W;

   pipe_state_t         r_state;
   pipe_state_t         w_state_nxt;
   logic                w_in_ready;
   logic                w_out_valid;
   logic                w_in_xfer;
   logic                w_out_xfer;
   logic                w_head_ld;
   logic                w_skid_ld;
   logic                w_head_sel_skid;
   logic [c_slot_w-1:0] w_in_word;
   logic [c_slot_w-1:0] w_head_d;
   logic [c_slot_w-1:0] w_head_q;
   logic [c_slot_w-1:0] w_skid_q;

   assign w_in_word   = {bus.in_ctrl, bus.in_data};
   assign w_out_valid = (r_state != EMPTY);

   // With a skid entry, in_ready is a pure function of the registered state so
   // the ready chain is cut here. Without it, a held entry can only be replaced
   // when the downstream consumes it in the same cycle.
   generate
      if (SKID != 0) begin : g_ready_skid
         assign w_in_ready = (r_state != TWO);
      end else begin : g_ready_single
         assign w_in_ready = (r_state == EMPTY) | bus.out_ready;
      end
   endgenerate

   assign w_in_xfer  = bus.in_valid & w_in_ready;
   assign w_out_xfer = w_out_valid & bus.out_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_head_ld       = 1'b0;
      w_skid_ld       = 1'b0;
      w_head_sel_skid = 1'b0;
      if (bus.flush) begin
         // in_ready still shows the pre-flush state; any accepted input is dropped.
         w_state_nxt = EMPTY;
      end else begin
         case (r_state)
            EMPTY: begin
               if (w_in_xfer) begin
                  w_state_nxt = ONE;
                  w_head_ld   = 1'b1;
               end
            end
            ONE: begin
               if (w_in_xfer && w_out_xfer) begin
                  w_head_ld = 1'b1;
               end else if (w_in_xfer) begin
                  // Only reachable with a skid entry: without one, in_ready in
                  // ONE implies out_ready, so an in-transfer pairs with an out-transfer.
                  w_state_nxt = TWO;
                  w_skid_ld   = 1'b1;
               end else if (w_out_xfer) begin
                  w_state_nxt = EMPTY;
               end
            end
            TWO: begin
               if (w_out_xfer) begin
                  w_state_nxt     = ONE;
                  w_head_ld       = 1'b1;
                  w_head_sel_skid = 1'b1;
               end
            end
            default: begin
               w_state_nxt = EMPTY;
            end
         endcase
      end
   end

   assign w_head_d = w_head_sel_skid ? w_skid_q : w_in_word;

   pipe_slot #(.W(c_slot_w)) u_head (
      .clk (clk),
      .rst (rst),
      .ld  (w_head_ld),
      .d   (w_head_d),
      .q   (w_head_q)
   );

   generate
      if (SKID != 0) begin : g_skid
         pipe_slot #(.W(c_slot_w)) u_skid (
            .clk (clk),
            .rst (rst),
            .ld  (w_skid_ld),
            .d   (w_in_word),
            .q   (w_skid_q)
         );
      end else begin : g_no_skid
         logic w_unused_skid_ld;
         assign w_unused_skid_ld = w_skid_ld;
         assign w_skid_q         = '0;
      end
   endgenerate

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.out_data  = w_head_q[DATA_W-1:0];
   assign bus.occupancy = occ_of(r_state);

   // A bubble must never present write-back or ecall bits downstream.
   generate
      if (CTRL_GATE != 0) begin : g_ctrl_gate
         assign bus.out_ctrl = w_out_valid ? w_head_q[c_slot_w-1:DATA_W] : '0;
      end else begin : g_ctrl_raw
         assign bus.out_ctrl = w_head_q[c_slot_w-1:DATA_W];
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : tb_pipe_stage_reg                                    |
// | Description : Scoreboard bench for pipe_stage_reg. dut_a uses the  |
// |               skid entry, dut_b is single entry. Stimulus pushes   |
// |               expected {ctrl,data} words; monitors pop on each     |
// |               out-transfer and compare.                            |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module tb_pipe_stage_reg;
   import pipe_pkg::*;

   localparam int DW = 32;
   localparam int CW = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) bus_a ();
   pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) bus_b ();

   pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CTRL_GATE(1)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a)
   );

   pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CTRL_GATE(1)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic [DW+CW-1:0] qa[$];
   logic [DW+CW-1:0] qb[$];
   logic [DW+CW-1:0] m_exp_a;
   logic [DW+CW-1:0] m_exp_b;

   int   occ_b;
   int   sent;
   int   cyc;
   logic exp_rdy;
   bit   [2:0] pat;

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endfunction

   // Monitors: compare every out-transfer against the head of the scoreboard.
   always @(negedge clk) begin
      if (rst && bus_a.out_valid && bus_a.out_ready) begin
         if (qa.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL a_out: got unexpected 0x%0h, expected no output", {bus_a.out_ctrl, bus_a.out_data});
         end else begin
            m_exp_a = qa.pop_front();
            check("a_out", {bus_a.out_ctrl, bus_a.out_data}, m_exp_a);
         end
      end
   end

   always @(negedge clk) begin
      if (rst && bus_b.out_valid && bus_b.out_ready) begin
         if (qb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL b_out: got unexpected 0x%0h, expected no output", {bus_b.out_ctrl, bus_b.out_data});
         end else begin
            m_exp_b = qb.pop_front();
            check("b_out", {bus_b.out_ctrl, bus_b.out_data}, m_exp_b);
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus_a.in_valid = 0; bus_a.in_data = '0; bus_a.in_ctrl = '0; bus_a.flush = 0; bus_a.out_ready = 0;
      bus_b.in_valid = 0; bus_b.in_data = '0; bus_b.in_ctrl = '0; bus_b.flush = 0; bus_b.out_ready = 0;

      // Reset state
      #2;
      check("rst_out_valid", bus_a.out_valid, 0);
      check("rst_occ",       bus_a.occupancy, 0);
      check("rst_in_ready",  bus_a.in_ready, 1);
      check("rst_out_data",  bus_a.out_data, 0);
      check("rst_out_ctrl",  bus_a.out_ctrl, 0);
      check("rst_b_in_ready", bus_b.in_ready, 1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;

      // Streaming with out_ready=1; last entry carries ctrl 0xFF
      bus_a.out_ready = 1;
      for (int i = 0; i < 8; i++) begin
         bus_a.in_valid = 1;
         bus_a.in_data  = 32'h100 + i;
         bus_a.in_ctrl  = (i == 7) ? 8'hFF : 8'(i + 1);
         @(negedge clk);
         check("t1_in_ready", bus_a.in_ready, 1);
         check("t1_occ_not2", bus_a.occupancy == 2'd2, 0);
         check("t1_valid",    bus_a.out_valid, (i > 0));
         qa.push_back({bus_a.in_ctrl, bus_a.in_data});
         @(posedge clk); #1;
      end
      bus_a.in_valid = 0;
      @(negedge clk);
      check("t4_ctrl_ff", bus_a.out_ctrl, 8'hFF);
      @(posedge clk); #1;
      @(negedge clk);
      check("t4_bubble_valid", bus_a.out_valid, 0);
      check("t4_ctrl_gated",   bus_a.out_ctrl, 0);
      check("t4_data_held",    bus_a.out_data, 32'h107);
      @(posedge clk); #1;

      // Backpressure: fill both entries, then drain
      bus_a.out_ready = 0;
      bus_a.in_valid = 1; bus_a.in_data = 32'hA; bus_a.in_ctrl = 8'h0A;
      @(negedge clk);
      check("t2_rdy_a", bus_a.in_ready, 1);
      qa.push_back({8'h0A, 32'hA});
      @(posedge clk); #1;
      bus_a.in_data = 32'hB; bus_a.in_ctrl = 8'h0B;
      @(negedge clk);
      check("t2_rdy_b", bus_a.in_ready, 1);
      qa.push_back({8'h0B, 32'hB});
      @(posedge clk); #1;
      bus_a.in_valid = 0;
      @(negedge clk);
      check("t2_occ2",     bus_a.occupancy, 2);
      check("t2_not_rdy",  bus_a.in_ready, 0);
      check("t2_head",     bus_a.out_data, 32'hA);
      @(posedge clk); #1;
      @(negedge clk);
      check("t2_head_held", bus_a.out_data, 32'hA);
      @(posedge clk); #1;
      bus_a.out_ready = 1;
      @(negedge clk);
      check("t2_rdy_no_comb", bus_a.in_ready, 0);
      @(posedge clk); #1;
      @(negedge clk);
      check("t2_rdy_after_pop", bus_a.in_ready, 1);
      check("t2_occ1",          bus_a.occupancy, 1);
      @(posedge clk); #1;

      // Flush while full, with a simultaneous input that must be dropped
      bus_a.out_ready = 0;
      bus_a.in_valid = 1; bus_a.in_data = 32'h1; bus_a.in_ctrl = 8'h01;
      @(negedge clk); qa.push_back({8'h01, 32'h1});
      @(posedge clk); #1;
      bus_a.in_data = 32'h2; bus_a.in_ctrl = 8'h02;
      @(negedge clk); qa.push_back({8'h02, 32'h2});
      @(posedge clk); #1;
      bus_a.in_data = 32'hC; bus_a.in_ctrl = 8'h0C; bus_a.flush = 1;
      @(negedge clk);
      check("t3_rdy_preflush", bus_a.in_ready, 0);
      check("t3_occ_preflush", bus_a.occupancy, 2);
      qa.delete();
      @(posedge clk); #1;
      bus_a.flush = 0; bus_a.in_valid = 0;
      @(negedge clk);
      check("t3_valid", bus_a.out_valid, 0);
      check("t3_occ",   bus_a.occupancy, 0);
      check("t3_ctrl",  bus_a.out_ctrl, 0);
      @(posedge clk); #1;
      // Flush while ONE with an accepted input
      bus_a.in_valid = 1; bus_a.in_data = 32'h3; bus_a.in_ctrl = 8'h03;
      @(negedge clk); qa.push_back({8'h03, 32'h3});
      @(posedge clk); #1;
      bus_a.in_data = 32'hD; bus_a.in_ctrl = 8'h0D; bus_a.flush = 1;
      @(negedge clk);
      check("t3b_rdy_preflush", bus_a.in_ready, 1);
      qa.delete();
      @(posedge clk); #1;
      bus_a.flush = 0; bus_a.in_valid = 0; bus_a.out_ready = 1;
      @(negedge clk);
      check("t3b_valid", bus_a.out_valid, 0);
      check("t3b_occ",   bus_a.occupancy, 0);
      repeat (3) begin @(posedge clk); #1; end

      // Asynchronous reset between edges while full
      bus_a.out_ready = 0;
      bus_a.in_valid = 1; bus_a.in_data = 32'h11; bus_a.in_ctrl = 8'h05;
      @(negedge clk); qa.push_back({8'h05, 32'h11});
      @(posedge clk); #1;
      bus_a.in_data = 32'h22; bus_a.in_ctrl = 8'h06;
      @(negedge clk); qa.push_back({8'h06, 32'h22});
      @(posedge clk); #1;
      bus_a.in_valid = 0;
      check("t5_occ2", bus_a.occupancy, 2);
      #2;
      rst = 1'b0;
      qa.delete();
      #1;
      check("t5_valid", bus_a.out_valid, 0);
      check("t5_occ",   bus_a.occupancy, 0);
      check("t5_data",  bus_a.out_data, 0);
      check("t5_ctrl",  bus_a.out_ctrl, 0);
      check("t5_rdy",   bus_a.in_ready, 1);
      bus_a.in_valid = 1; bus_a.in_data = 32'h77; bus_a.in_ctrl = 8'h07;
      @(posedge clk); #1;
      check("t5_no_xfer_in_rst", bus_a.out_valid, 0);
      @(negedge clk);
      rst = 1'b1;
      bus_a.out_ready = 1;
      check("t5_rdy_release", bus_a.in_ready, 1);
      qa.push_back({8'h07, 32'h77});
      @(posedge clk); #1;
      bus_a.in_valid = 0;
      repeat (3) begin @(posedge clk); #1; end

      // Single-entry variant: out_ready pattern 1,0,1 under continuous in_valid
      occ_b = 0; sent = 0; cyc = 0; pat = 3'b101;
      while (sent < 8 && cyc < 40) begin
         bus_b.in_valid  = 1;
         bus_b.in_data   = 32'h200 + sent;
         bus_b.in_ctrl   = 8'(sent + 16);
         bus_b.out_ready = pat[cyc % 3];
         @(negedge clk);
         exp_rdy = (occ_b == 0) || bus_b.out_ready;
         check("b_in_ready", bus_b.in_ready, exp_rdy);
         check("b_occ",      bus_b.occupancy, occ_b);
         if (exp_rdy) begin
            qb.push_back({bus_b.in_ctrl, bus_b.in_data});
            sent++;
         end
         occ_b = occ_b + (exp_rdy ? 1 : 0) - (((occ_b == 1) && bus_b.out_ready) ? 1 : 0);
         @(posedge clk); #1;
         cyc++;
      end
      if (sent < 8) check("b_timeout", sent, 8);
      bus_b.in_valid = 0; bus_b.out_ready = 1;
      repeat (3) begin @(posedge clk); #1; end

      check("a_drain", qa.size(), 0);
      check("b_drain", qb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
